pll_reset_sequencer: RTL and testbench
======================================

Name: pll_reset_sequencer

Overview:
Controller on the far side of the PLL lock/reset interface: drives the PLL's active-high reset and consumes its asynchronous locked output. It resets the PLL, waits for a lock that stays stable, then releases per-clock-domain resets one at a time in a fixed order. If lock is lost, it re-resets the PLL and retries up to a limit, then reports failure. Runs on the free-running 50 MHz reference clock, next to the PLL wrapper in the board top level.

Parameters:
NUM_DOMAINS, 4, number of sequenced domain reset outputs
SYNC_STAGES, 2, flops in the locked synchronizer (minimum 2)
PLL_RST_CYCLES, 16, cycles pll_rst_out is held high per attempt
LOCK_TIMEOUT_CYCLES, 65536, max cycles in WAIT_LOCK before a retry
STABLE_CYCLES, 1024, consecutive synchronized-locked cycles required
GAP_CYCLES, 8, cycles between successive domain releases
MAX_RETRIES, 3, retries allowed before FAIL

Ports:
clock_in  input  1  reference clock, free-running
reset_in  input  1  asynchronous active-low reset
pll_locked_in  input  1  PLL locked, asynchronous to clock_in
pll_rst_out  output  1  PLL reset, active high
domain_reset_out  output  NUM_DOMAINS  per-domain reset, active low; bit 0 released first
ready_out  output  1  high while in RUN
fail_out  output  1  sticky failure flag
retry_count_out  output  4  retries used since reset_in, saturates at 15
lock_lost_out  output  1  one-cycle pulse when lock drops in RUN or RELEASE

Behaviour:
- Reset (reset_in=0, asynchronous): state=PLL_RESET, all counters 0, synchronizer flops 0, pll_rst_out=1, domain_reset_out=all 0, ready_out=0, fail_out=0, retry_count_out=0, lock_lost_out=0.
- Synchronizer: SYNC_STAGES flops; lk denotes the last stage. All decisions use lk only.
- Single cycle counter cnt, cleared on every state transition. Counter width covers the largest parameter.
- PLL_RESET: pll_rst_out=1. After PLL_RST_CYCLES cycles (cnt==PLL_RST_CYCLES-1), go to WAIT_LOCK.
- WAIT_LOCK: pll_rst_out=0.
  - lk=1: go to STABLE.
  - cnt reaches LOCK_TIMEOUT_CYCLES-1 with lk=0: take the retry path.
- STABLE: each cycle with lk=1 increments cnt.
  - lk=0: return to WAIT_LOCK. This is not a retry; the timeout counter restarts from 0.
  - cnt==STABLE_CYCLES-1 with lk=1: go to RELEASE, domain index d=0.
- RELEASE: domain_reset_out[d] is set to 1 on entry, then GAP_CYCLES cycles elapse before d+1 is released.
  - After the last domain is released and GAP_CYCLES have elapsed, go to RUN.
  - Released bits stay 1 until lock loss.
- RUN: ready_out=1, registered. It asserts on the first RUN cycle and drops on the same edge the state leaves RUN.
- Lock loss (lk=0 in RELEASE or RUN):
  - On the next edge, domain_reset_out=all 0 and ready_out=0.
  - lock_lost_out pulses for 1 cycle.
  - Then take the retry path.
- Retry path:
  - retries < MAX_RETRIES: increment the retry count, go to PLL_RESET.
  - otherwise: go to FAIL.
- FAIL: pll_rst_out=1, domain_reset_out=all 0, fail_out=1. Absorbing; the only exit is reset_in.
- Simultaneous events:
  - Lock loss on the same cycle as a gap expiry: lock loss wins, no further bit is released.
  - Timeout expiry on the cycle lk rises: lock wins, go to STABLE.
- Latency (lk asserted from the start of WAIT_LOCK, ignoring synchronizer delay): domain bit k is released STABLE_CYCLES + k*GAP_CYCLES + 1 cycles after WAIT_LOCK entry. Fixed for a given parameter set.
- All outputs are registered, with no combinational path from pll_locked_in.
- reset_in asserted mid-sequence: immediate return to the reset values above.

Decomposition:
- Shared package pll_seq_pkg: state enum (PLL_RESET, WAIT_LOCK, STABLE, RELEASE, RUN, FAIL) and a function that computes counter width from the largest parameter.
- One sub-module, sync_ff: parameterized SYNC_STAGES-deep async-input synchronizer with active-low async clear. It is reused elsewhere for other async status inputs.

Test Plan:
- Nominal, with PLL_RST_CYCLES=16, STABLE_CYCLES=32, GAP_CYCLES=4, MAX_RETRIES=3, LOCK_TIMEOUT_CYCLES=200:
  - Stimulus: reset_in released, locked rises 10 cycles after pll_rst_out falls.
  - Required: pll_rst_out high exactly 16 cycles; domain bits release in order 0..3, 4 cycles apart; ready_out=1 after bit 3 plus 4 cycles; retry_count_out=0.
- Glitchy lock:
  - Stimulus: locked high 20 cycles, low 1, then high.
  - Required: no domain release until 32 continuous lk cycles; retry_count_out stays 0; pll_rst_out not re-asserted.
- Timeout:
  - Stimulus: locked held 0.
  - Required: pll_rst_out re-asserts every 16+200 cycles, 3 times; then fail_out=1, pll_rst_out=1, domain_reset_out=0000, retry_count_out=3.
- Lock loss in RUN:
  - Stimulus: drop locked.
  - Required: within SYNC_STAGES+1 cycles, domain_reset_out=0000, ready_out=0, lock_lost_out single pulse, retry_count_out=1; PLL_RESET re-entered and the sequence restarts.
- Lock loss mid-RELEASE:
  - Stimulus: drop locked after bit 1 released.
  - Required: all bits cleared, bits 2 and 3 never released, retry taken.
- Async reset:
  - Stimulus: reset_in asserted mid-RELEASE and mid-FAIL.
  - Required: outputs reach reset values without a clock edge, and the nominal sequence repeats after release.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL reset sequencer.
//   state_t   : sequencer FSM states
//   cnt_width : width of the single cycle counter, sized from the largest
//               count parameter so that (param - 1) always fits.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    PLL_RESET,
    WAIT_LOCK,
    STABLE,
    RELEASE,
    RUN,
    FAIL
  } state_t;

  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return ($clog2(m) < 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous status input.
//   clk   : destination clock
//   rst_n : asynchronous active-low clear (all stages to 0)
//   d     : asynchronous input
//   q     : synchronized output (last stage)
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff <= '0;
    else        ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset / lock sequencer on the free-running reference clock.
// Resets the PLL, waits for a stable lock, then releases per-domain resets
// one at a time (bit 0 first). Lock loss or lock timeout re-resets the PLL,
// up to MAX_RETRIES times, after which the block parks in FAIL.
//   clock_in         : reference clock
//   reset_in         : asynchronous active-low reset
//   pll_locked_in    : PLL locked, asynchronous (synchronized internally)
//   pll_rst_out      : PLL reset, active high
//   domain_reset_out : per-domain resets, active low
//   ready_out        : high while in RUN
//   fail_out         : sticky failure flag
//   retry_count_out  : retries used, saturating at 15
//   lock_lost_out    : one-cycle pulse on lock loss in RELEASE or RUN
// All outputs come straight from flops; pll_locked_in only reaches the FSM
// through the synchronizer.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int NUM_DOMAINS         = 4,
  parameter int SYNC_STAGES         = 2,
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int STABLE_CYCLES       = 1024,
  parameter int GAP_CYCLES          = 8,
  parameter int MAX_RETRIES         = 3
) (
  input  logic                   clock_in,
  input  logic                   reset_in,
  input  logic                   pll_locked_in,
  output logic                   pll_rst_out,
  output logic [NUM_DOMAINS-1:0] domain_reset_out,
  output logic                   ready_out,
  output logic                   fail_out,
  output logic [3:0]             retry_count_out,
  output logic                   lock_lost_out
);

  localparam int CNT_W = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES, STABLE_CYCLES, GAP_CYCLES);
  localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DOMAINS - 1);

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [3:0]             retry_q, retry_d;
  logic [NUM_DOMAINS-1:0] dom_q, dom_d;
  logic                   pll_rst_q, ready_q, fail_q, lost_q;
  logic                   lost_d, retry_go, lk;

  sync_ff #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk   (clock_in),
    .rst_n (reset_in),
    .d     (pll_locked_in),
    .q     (lk)
  );

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q   <= PLL_RESET;
      cnt_q     <= '0;
      idx_q     <= '0;
      retry_q   <= '0;
      dom_q     <= '0;
      pll_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
      lost_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      retry_q   <= retry_d;
      dom_q     <= dom_d;
      // Outputs are decoded from the next state so they change on the
      // same edge as the state itself.
      pll_rst_q <= (state_d == PLL_RESET) || (state_d == FAIL);
      ready_q   <= (state_d == RUN);
      fail_q    <= (state_d == FAIL);
      lost_q    <= lost_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CNT_W'(1);
    idx_d    = idx_q;
    retry_d  = retry_q;
    dom_d    = dom_q;
    lost_d   = 1'b0;
    retry_go = 1'b0;

    case (state_q)
      PLL_RESET: begin
        if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        // Lock wins over a coincident timeout.
        if (lk)                     state_d  = STABLE;
        else if (cnt_q == TMO_LAST) retry_go = 1'b1;
      end
      STABLE: begin
        // A dropout here just restarts the lock wait; it is not a retry.
        if (!lk) begin
          state_d = WAIT_LOCK;
        end else if (cnt_q == STB_LAST) begin
          state_d = RELEASE;
          idx_d   = '0;
          dom_d   = NUM_DOMAINS'(1);
        end
      end
      RELEASE: begin
        // Lock loss is checked first so it beats a coincident gap expiry.
        if (!lk) begin
          lost_d   = 1'b1;
          retry_go = 1'b1;
        end else if (cnt_q == GAP_LAST) begin
          if (idx_q == IDX_LAST) begin
            state_d = RUN;
          end else begin
            idx_d = idx_q + IDX_W'(1);
            dom_d = dom_q | (NUM_DOMAINS'(1) << (idx_q + IDX_W'(1)));
            cnt_d = '0;
          end
        end
      end
      RUN: begin
        cnt_d = cnt_q;
        if (!lk) begin
          lost_d   = 1'b1;
          retry_go = 1'b1;
        end
      end
      FAIL: begin
        cnt_d = cnt_q;
      end
      default: begin
        state_d = PLL_RESET;
      end
    endcase

    if (retry_go) begin
      dom_d = '0;
      if (int'(retry_q) < MAX_RETRIES) begin
        retry_d = (retry_q == 4'hF) ? retry_q : retry_q + 4'd1;
        state_d = PLL_RESET;
      end else begin
        state_d = FAIL;
      end
    end

    if (state_d != state_q) cnt_d = '0;
  end

  assign pll_rst_out      = pll_rst_q;
  assign domain_reset_out = dom_q;
  assign ready_out        = ready_q;
  assign fail_out         = fail_q;
  assign retry_count_out  = retry_q;
  assign lock_lost_out    = lost_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer with small timing parameters.
// Every change of the output vector is matched against a queue of expected
// {cycle, outputs} records pushed when the stimulus is driven.
module tb_pll_reset_sequencer;

  localparam int W = 44;  // 32-bit cycle stamp + 12 output bits

  logic       clock_in = 1'b0;
  logic       reset_in;
  logic       pll_locked_in;
  logic       pll_rst_out;
  logic [3:0] domain_reset_out;
  logic       ready_out;
  logic       fail_out;
  logic [3:0] retry_count_out;
  logic       lock_lost_out;

  pll_reset_sequencer #(
    .NUM_DOMAINS         (4),
    .SYNC_STAGES         (2),
    .PLL_RST_CYCLES      (16),
    .LOCK_TIMEOUT_CYCLES (200),
    .STABLE_CYCLES       (32),
    .GAP_CYCLES          (4),
    .MAX_RETRIES         (3)
  ) dut (
    .clock_in         (clock_in),
    .reset_in         (reset_in),
    .pll_locked_in    (pll_locked_in),
    .pll_rst_out      (pll_rst_out),
    .domain_reset_out (domain_reset_out),
    .ready_out        (ready_out),
    .fail_out         (fail_out),
    .retry_count_out  (retry_count_out),
    .lock_lost_out    (lock_lost_out)
  );

  // ---------------- clock / cycle counter ----------------
  always #10 clock_in = ~clock_in;

  int cyc = 0;
  always @(posedge clock_in) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           n_tests = 0;
  int           n_fail  = 0;
  logic         mon_en  = 1'b0;
  logic [11:0]  prev_out;
  logic [11:0]  outs;

  assign outs = {pll_rst_out, domain_reset_out, ready_out, fail_out, retry_count_out, lock_lost_out};

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got cyc=%0d out=%03h, want cyc=%0d out=%03h",
               tag, got[W-1:12], got[11:0], want[W-1:12], want[11:0]);
    end
  endtask

  function automatic logic [11:0] ov(input logic p, input logic [3:0] d, input logic r,
                                     input logic f, input logic [3:0] rc, input logic l);
    return {p, d, r, f, rc, l};
  endfunction

  // Monitor: sample on the falling edge, compare each output change.
  always @(negedge clock_in) begin
    if (mon_en && outs !== prev_out) begin
      if (exp_q.size() == 0) check("extra_evt", {cyc, outs}, '0);
      else                   check("evt", {cyc, outs}, exp_q.pop_front());
    end
    prev_out = outs;
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clock_in);
    #5;
  endtask

  task automatic push(input int c, input logic [11:0] v);
    exp_q.push_back({32'(c), v});
  endtask

  // lk is first seen high at edge l; bit k follows at l+33+4k, RUN at l+49.
  task automatic push_release(input int l, input logic [3:0] rc, input int nbits);
    for (int k = 0; k < nbits; k++)
      push(l + 33 + 4 * k, ov(1'b0, 4'((1 << (k + 1)) - 1), 1'b0, 1'b0, rc, 1'b0));
    if (nbits == 4) push(l + 49, ov(1'b0, 4'hF, 1'b1, 1'b0, rc, 1'b0));
  endtask

  task automatic drain(input string tag);
    check(tag, 44'(exp_q.size()), 44'd0);
    exp_q.delete();
  endtask

  task automatic async_reset(input string tag);
    mon_en        = 1'b0;
    reset_in      = 1'b0;
    pll_locked_in = 1'b0;
    #1;
    check(tag, {32'd0, outs}, {32'd0, ov(1'b1, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0)});
    step(2);
  endtask

  // Release reset and run to RUN; optional one-cycle lock glitch.
  task automatic run_nominal(input bit glitch);
    int c0;
    reset_in = 1'b1;
    mon_en   = 1'b1;
    c0       = cyc;
    push(c0 + 16, ov(1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0));
    step(26);
    pll_locked_in = 1'b1;
    if (glitch) begin
      step(20);
      pll_locked_in = 1'b0;
      step(1);
      pll_locked_in = 1'b1;
    end
    push_release(cyc + 2, 4'h0, 4);
    step(60);
    drain(glitch ? "glitch_done" : "nominal_done");
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int c1, l, b1;
    reset_in      = 1'b0;
    pll_locked_in = 1'b0;
    step(3);
    check("rst_vals", {32'd0, outs}, {32'd0, ov(1'b1, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0)});

    // Nominal bring-up
    run_nominal(1'b0);

    // Lock loss in RUN: pulse, retry 1, sequence restarts
    c1 = cyc;
    pll_locked_in = 1'b0;
    push(c1 + 3,  ov(1'b1, 4'h0, 1'b0, 1'b0, 4'h1, 1'b1));
    push(c1 + 4,  ov(1'b1, 4'h0, 1'b0, 1'b0, 4'h1, 1'b0));
    push(c1 + 19, ov(1'b0, 4'h0, 1'b0, 1'b0, 4'h1, 1'b0));
    step(24);
    pll_locked_in = 1'b1;
    l  = cyc + 2;
    b1 = l + 37;
    push_release(l, 4'h1, 2);
    // Drop lock so the loss lands on the bit-2 gap expiry edge.
    step(b1 + 1 - cyc);
    pll_locked_in = 1'b0;
    push(b1 + 4,  ov(1'b1, 4'h0, 1'b0, 1'b0, 4'h2, 1'b1));
    push(b1 + 5,  ov(1'b1, 4'h0, 1'b0, 1'b0, 4'h2, 1'b0));
    push(b1 + 20, ov(1'b0, 4'h0, 1'b0, 1'b0, 4'h2, 1'b0));
    step(30);
    drain("loss_release_done");

    // Relock, then async reset mid-RELEASE
    pll_locked_in = 1'b1;
    push_release(cyc + 2, 4'h2, 1);
    step(37);
    drain("pre_reset_release");
    async_reset("async_rst_release");
    run_nominal(1'b0);

    // Glitchy lock
    async_reset("async_rst_run");
    run_nominal(1'b1);

    // Timeout path into FAIL
    async_reset("async_rst_run2");
    reset_in = 1'b1;
    mon_en   = 1'b1;
    c1       = cyc;
    for (int r = 0; r < 3; r++) begin
      push(c1 + 16 + 216 * r, ov(1'b0, 4'h0, 1'b0, 1'b0, 4'(r), 1'b0));
      push(c1 + 216 * (r + 1), ov(1'b1, 4'h0, 1'b0, 1'b0, 4'(r + 1), 1'b0));
    end
    push(c1 + 16 + 648, ov(1'b0, 4'h0, 1'b0, 1'b0, 4'h3, 1'b0));
    push(c1 + 864,      ov(1'b1, 4'h0, 1'b0, 1'b1, 4'h3, 1'b0));
    step(900);
    pll_locked_in = 1'b1;  // FAIL must ignore a late lock
    step(100);
    drain("fail_done");

    // Async reset mid-FAIL, then nominal again
    async_reset("async_rst_fail");
    run_nominal(1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
